// File: rtl/digit_blit_sched.sv
`timescale 1ns/1ps
// Round-robin glyph blitter: one requester's 24x32 digit copied from the shared ROM into the frame buffer.
// Latency: first fb_we one cycle after entering COPY, 1 pixel/cycle, done 770 cycles after grant at full rate.
// Backpressure: fb_we/fb_addr/fb_data held and counters frozen while fb_ready is low; TRANSPARENT_KEY_EN skips key pixels.
module digit_blit_sched #(
  parameter int NREQ      = 2,
  parameter int GLYPH_H   = 24,
  parameter int GLYPH_W   = 32,
  parameter int PIX_W     = 10,
  parameter int FB_W      = 640,
  parameter int FB_H      = 480,
  parameter int FB_AW     = 19,
  parameter int KEY_COLOR = 391
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_digit,
  input  logic [10*NREQ-1:0] req_x,
  input  logic [9*NREQ-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic [3:0]        rom_digit,
  output logic [4:0]        rom_row,
  output logic [4:0]        rom_col,
  input  logic [PIX_W-1:0]  rom_pixel,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [PIX_W-1:0]  fb_data,
  input  logic              fb_ready,
  output logic              busy,
  output logic [NREQ-1:0]   done
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, COPY, DRAIN} state_t;

  state_t         state;
  logic [RW-1:0]  rr, gidx, gnt_idx;
  logic           gnt_any;
  logic [3:0]     dig;
  logic [9:0]     bx;
  logic [8:0]     by;
  logic [4:0]     row, col;
  logic [10:0]    xs;
  logic [9:0]     ys;
  logic           in_frame, wen, load, last;
  logic [PIX_W-1:0] pix;
  logic [FB_AW-1:0] addr;
  int             cand;

  // First pending requester at or after the rotating pointer.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr) + k) % NREQ;
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = RW'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (Reset_n && state == IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign busy      = (state != IDLE);
  assign rom_digit = (state == COPY) ? dig : 4'd0;
  assign rom_row   = (state == COPY) ? row : 5'd0;
  assign rom_col   = (state == COPY) ? col : 5'd0;

  assign xs       = {1'b0, bx} + {6'd0, col};
  assign ys       = {1'b0, by} + {5'd0, row};
  assign in_frame = (xs < 11'(FB_W)) && (ys < 10'(FB_H));
  // Out-of-range glyph indices read as fully transparent.
  assign pix      = (dig > 4'd9) ? PIX_W'(KEY_COLOR) : rom_pixel;
`ifdef TRANSPARENT_KEY_EN
  assign wen      = in_frame && (pix != PIX_W'(KEY_COLOR));
`else
  assign wen      = in_frame;
`endif
  assign addr     = FB_AW'(ys) * FB_AW'(FB_W) + FB_AW'(xs);
  assign load     = !fb_we || fb_ready;
  assign last     = (row == 5'(GLYPH_H - 1)) && (col == 5'(GLYPH_W - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      rr      <= '0;
      gidx    <= '0;
      dig     <= '0;
      bx      <= '0;
      by      <= '0;
      row     <= '0;
      col     <= '0;
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
      done    <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: if (gnt_any) begin
          gidx  <= gnt_idx;
          dig   <= req_digit[int'(gnt_idx)*4 +: 4];
          bx    <= req_x[int'(gnt_idx)*10 +: 10];
          by    <= req_y[int'(gnt_idx)*9 +: 9];
          row   <= '0;
          col   <= '0;
          rr    <= (gnt_idx == RW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state <= COPY;
        end
        COPY: if (load) begin
          fb_we   <= wen;
          fb_addr <= addr;
          fb_data <= pix;
          if (col == 5'(GLYPH_W - 1)) begin
            col <= '0;
            row <= row + 5'd1;
          end else begin
            col <= col + 5'd1;
          end
          if (last) state <= DRAIN;
        end
        DRAIN: if (load) begin
          fb_we      <= 1'b0;
          done[gidx] <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_blit_sched.sv
`timescale 1ns/1ps
// Directed bench for digit_blit_sched: glyph copy, arbitration order, stalls, clipping, bad digit, reset mid-blit.
module tb_digit_blit_sched;

  localparam int NREQ = 2;
  localparam int KEY  = 391;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [4*NREQ-1:0] req_digit = '0;
  logic [10*NREQ-1:0] req_x = '0;
  logic [9*NREQ-1:0] req_y = '0;
  logic [NREQ-1:0]   req_ready;
  logic [3:0]        rom_digit;
  logic [4:0]        rom_row, rom_col;
  logic [9:0]        rom_pixel;
  logic              fb_we;
  logic [18:0]       fb_addr;
  logic [9:0]        fb_data;
  logic              fb_ready = 1'b1;
  logic              busy;
  logic [NREQ-1:0]   done;

  digit_blit_sched dut (
    .Clk(Clk), .Reset_n(Reset_n), .req_valid(req_valid), .req_digit(req_digit),
    .req_x(req_x), .req_y(req_y), .req_ready(req_ready), .rom_digit(rom_digit),
    .rom_row(rom_row), .rom_col(rom_col), .rom_pixel(rom_pixel), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  // Glyph ROM stand-in: key colour only in the top padding rows, never 391 elsewhere.
  function automatic logic [9:0] rom_f(input logic [3:0] d, input logic [4:0] r, input logic [4:0] c);
    int v;
    if (r < 5'd4 && ((int'(c) + int'(d)) % 3 == 0)) return 10'(KEY);
    v = (int'(d) * 37 + int'(r) * 11 + int'(c) * 5 + 1) % 1024;
    if (v == KEY) v = KEY + 1;
    return 10'(v);
  endfunction

  assign rom_pixel = rom_f(rom_digit, rom_row, rom_col);

  int          checks = 0;
  int          errors = 0;
  logic [28:0] wr_q[$];
  logic [28:0] exp_q[$];
  int          gnt_q[$];
  longint      gnt_cyc_q[$];
  int          done_cnt[NREQ];
  longint      done_cyc = 0;
  longint      cyc = 0;
  int          stall_err = 0;
  bit          prev_stall = 0;
  logic [28:0] pw = '0;
  bit          rnd_rdy = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  initial forever begin
    @(posedge Clk);
    #1 fb_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Observer: accepted writes, grants, done pulses, and stall stability.
  initial forever begin
    @(negedge Clk);
    if (!Reset_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (fb_we !== 1'b1 || {fb_addr, fb_data} !== pw)) stall_err++;
      prev_stall = fb_we && !fb_ready;
      pw = {fb_addr, fb_data};
      if (fb_we && fb_ready) wr_q.push_back({fb_addr, fb_data});
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          gnt_q.push_back(i);
          gnt_cyc_q.push_back(cyc);
        end
        if (done[i]) begin
          done_cnt[i]++;
          done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    wr_q.delete();
    exp_q.delete();
    gnt_q.delete();
    gnt_cyc_q.delete();
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
    stall_err = 0;
  endtask

  task automatic do_reset();
    req_valid = '0;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic add_exp(input int d, input int x, input int y);
    int xs, ys, p;
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 32; c++) begin
        xs = x + c;
        ys = y + r;
        if (xs < 640 && ys < 480) begin
          p = (d > 9) ? KEY : int'(rom_f(4'(d), 5'(r), 5'(c)));
`ifdef TRANSPARENT_KEY_EN
          if (p != KEY)
`endif
          exp_q.push_back({19'(ys * 640 + xs), 10'(p)});
        end
      end
  endtask

  task automatic set_req(input int idx, input logic [3:0] d, input logic [9:0] x, input logic [8:0] y);
    req_digit[idx*4 +: 4] = d;
    req_x[idx*10 +: 10]   = x;
    req_y[idx*9 +: 9]     = y;
  endtask

  task automatic do_req(input int idx, input logic [3:0] d, input logic [9:0] x, input logic [8:0] y);
    int n = 0;
    set_req(idx, d, x, y);
    req_valid[idx] = 1'b1;
    @(negedge Clk);
    while (!req_ready[idx] && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 2000) check("req_ready_timeout", 0, 1);
    @(posedge Clk);
    #1 req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge Clk);
    while (busy && n < budget) begin
      @(negedge Clk);
      n++;
    end
    if (n >= budget) check("idle_timeout", 0, 1);
    @(negedge Clk);
  endtask

  task automatic compare_writes(input string tag);
    int mism = 0;
    int n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    check({tag, "_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) if (wr_q[i] !== exp_q[i]) mism++;
    check({tag, "_mismatch"}, mism, 0);
  endtask

  function automatic longint max_addr();
    longint m = -1;
    foreach (wr_q[i]) if (longint'(wr_q[i][28:10]) > m) m = longint'(wr_q[i][28:10]);
    return m;
  endfunction

  initial begin
    int n;
    for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
    // Reset values, with requests pending to confirm req_ready is held low.
    #3 Reset_n = 1'b0;
    req_valid = 2'b11;
    #2;
    check("rst_busy", busy, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_done", done, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_rom_row", rom_row, 0);
    do_reset();

    // Full glyph at origin, fb always ready.
    add_exp(2, 0, 0);
    do_req(0, 4'd2, 10'd0, 9'd0);
    wait_idle(2000);
    compare_writes("t1");
`ifndef TRANSPARENT_KEY_EN
    check("t1_writes768", wr_q.size(), 768);
`endif
    check("t1_max_addr", max_addr(), 14751);
    check("t1_done0", done_cnt[0], 1);
    check("t1_grant_to_done", done_cyc - gnt_cyc_q[0], 770);

    // Both requesters pending continuously.
    do_reset();
    set_req(0, 4'd1, 10'd40, 9'd20);
    set_req(1, 4'd3, 10'd200, 9'd100);
    add_exp(1, 40, 20);
    add_exp(3, 200, 100);
    add_exp(1, 40, 20);
    add_exp(3, 200, 100);
    req_valid = 2'b11;
    n = 0;
    while (gnt_q.size() < 4 && n < 5000) begin
      @(negedge Clk);
      n++;
    end
    @(posedge Clk);
    #1 req_valid = '0;
    wait_idle(2000);
    check("t2_ngrants", gnt_q.size(), 4);
    for (int i = 0; i < gnt_q.size(); i++) check("t2_grant_order", gnt_q[i], i % 2);
    if (gnt_cyc_q.size() >= 2) check("t2_grant_gap", gnt_cyc_q[1] - gnt_cyc_q[0], 770);
    compare_writes("t2");
    check("t2_done0", done_cnt[0], 2);
    check("t2_done1", done_cnt[1], 2);

    // Random backpressure.
    do_reset();
    rnd_rdy = 1;
    add_exp(7, 100, 50);
    do_req(0, 4'd7, 10'd100, 9'd50);
    wait_idle(6000);
    rnd_rdy = 0;
    compare_writes("t3");
    check("t3_stall_stable", stall_err, 0);
    check("t3_done0", done_cnt[0], 1);

    // Bottom-right clipping.
    do_reset();
    add_exp(5, 620, 470);
    do_req(1, 4'd5, 10'd620, 9'd470);
    wait_idle(2000);
    compare_writes("t4");
`ifndef TRANSPARENT_KEY_EN
    check("t4_writes200", wr_q.size(), 200);
`endif
    check("t4_max_addr", max_addr(), 307199);
    check("t4_done1", done_cnt[1], 1);

    // Glyph index beyond 9 reads as key colour.
    do_reset();
    add_exp(12, 10, 10);
    do_req(0, 4'd12, 10'd10, 9'd10);
    wait_idle(2000);
    compare_writes("t5");
`ifdef TRANSPARENT_KEY_EN
    check("t5_writes0", wr_q.size(), 0);
`else
    check("t5_writes768", wr_q.size(), 768);
`endif

    // Reset in the middle of a blit.
    do_reset();
    do_req(0, 4'd4, 10'd0, 9'd0);
    n = 0;
    while (wr_q.size() < 100 && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    check("t6_reached100", wr_q.size() >= 100, 1);
    req_valid = 2'b11;
    #2 Reset_n = 1'b0;
    #1;
    check("t6_rst_fb_we", fb_we, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_req_ready", req_ready, 0);
    check("t6_rst_fb_addr", fb_addr, 0);
    check("t6_rst_rom_col", rom_col, 0);
    repeat (3) @(posedge Clk);
    check("t6_no_done", done_cnt[0] + done_cnt[1], 0);
    clear_logs();
    set_req(0, 4'd9, 10'd3, 9'd2);
    add_exp(9, 3, 2);
    #1 Reset_n = 1'b1;
    n = 0;
    while (gnt_q.size() < 1 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    @(posedge Clk);
    #1 req_valid = '0;
    wait_idle(2000);
    check("t6_first_grant", (gnt_q.size() > 0) ? gnt_q[0] : -1, 0);
    compare_writes("t6");
    check("t6_done0", done_cnt[0], 1);
    check("t6_done1", done_cnt[1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
